// File: rtl/edge_det_pkg.sv
// Shared types for the multi-channel edge detector: the per-channel detect mode
// and the rule that turns a rise/fall observation into an event.
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  function automatic logic edge_hit(edge_mode_t m, logic rise, logic fall);
    return ((m == EDGE_RISE || m == EDGE_BOTH) && rise) ||
           ((m == EDGE_FALL || m == EDGE_BOTH) && fall);
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One detector channel: optional synchroniser, previous-sample flop, event decode,
// retriggerable pulse stretcher, sticky flag and saturating event counter.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  edge_mode_t       mode,
  input  logic             clr,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam int ST_W = $clog2(PULSE_LEN + 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(PULSE_LEN - 1);

  logic            s;
  logic            prev_q;
  logic            rise;
  logic            fall;
  logic            hit;
  logic [ST_W-1:0] stretch_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;
  assign hit  = edge_hit(mode, rise, fall);

  // NOTE: non-blocking assignments so every flop here samples pre-edge values,
  // which is what makes prev_q a true one-cycle delay of s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= 1'b0;
      dout      <= 1'b0;
      stretch_q <= '0;
      sticky    <= 1'b0;
      cnt       <= '0;
    end else begin
      prev_q <= s;

      // A new event reloads the stretch, so retriggers never open a gap.
      if (hit) begin
        dout      <= 1'b1;
        stretch_q <= ST_LOAD;
      end else if (stretch_q != '0) begin
        stretch_q <= stretch_q - ST_W'(1);
      end else begin
        dout <= 1'b0;
      end

      if (hit)      sticky <= 1'b1;
      else if (clr) sticky <= 1'b0;

      if (cnt_clr)               cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: WIDTH independent channels, each with its own
// mode, sticky flag and saturating counter; outputs are all registered.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       din,
  input  logic [2*WIDTH-1:0]     mode,
  input  logic [WIDTH-1:0]       clr,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       sticky,
  output logic [WIDTH*CNT_W-1:0] cnt
);

  if (WIDTH < 1) begin : g_bad_width
    $error("multi_edge_detector: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 0) begin : g_bad_sync
    $error("multi_edge_detector: SYNC_STAGES must be >= 0");
  end
  if (PULSE_LEN < 1) begin : g_bad_pulse
    $error("multi_edge_detector: PULSE_LEN must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("multi_edge_detector: CNT_W must be >= 1");
  end

  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .PULSE_LEN  (PULSE_LEN),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .din    (din[ch]),
      .mode   (edge_mode_t'(mode[2*ch +: 2])),
      .clr    (clr[ch]),
      .cnt_clr(cnt_clr),
      .dout   (dout[ch]),
      .sticky (sticky[ch]),
      .cnt    (cnt[CNT_W*ch +: CNT_W])
    );
  end

endmodule
